// File: rtl/update_counter_ctrl_if.sv
// Consumer-side address stream of the update counter controller: address,
// valid/ready handshake and per-beat position information.
interface update_counter_ctrl_if #(
  parameter int unsigned CsrDataWidth = 32
);
  logic [CsrDataWidth-1:0] addr;
  logic                    addr_valid;
  logic                    addr_ready;
  logic                    sample_last;
  logic [CsrDataWidth-1:0] elem_idx;
  logic [CsrDataWidth-1:0] sample_idx;

  modport master (
    output addr, addr_valid, sample_last, elem_idx, sample_idx,
    input  addr_ready
  );

  modport slave (
    input  addr, addr_valid, sample_last, elem_idx, sample_idx,
    output addr_ready
  );
endinterface

// File: rtl/update_counter_ctrl.sv
// Job sequencer for the item-memory address counter: latches a job config,
// drives the counter controls and walks num_samples x num_elem address beats.
module update_counter_ctrl #(
  parameter int unsigned CsrDataWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    wait_ack_i,
  input  logic [CsrDataWidth-1:0] num_elem_i,
  input  logic [CsrDataWidth-1:0] num_samples_i,
  input  logic [CsrDataWidth-1:0] start_count_i,
  input  logic                    sample_ack_i,
  output logic                    cnt_en_o,
  output logic                    cnt_start_o,
  output logic                    cnt_clr_o,
  output logic [CsrDataWidth-1:0] cnt_max_count_o,
  output logic [CsrDataWidth-1:0] cnt_start_count_o,
  input  logic [CsrDataWidth-1:0] cnt_addr_i,
  input  logic                    cnt_addr_valid_i,
  output logic                    cnt_addr_ready_o,
  update_counter_ctrl_if.master   addr_if,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_e;

  localparam logic [CsrDataWidth-1:0] One = CsrDataWidth'(1);

  state_e                  state_q, state_d;
  logic [CsrDataWidth-1:0] num_elem_q, num_samples_q, start_count_q;
  logic [CsrDataWidth-1:0] elem_idx_q, elem_idx_d;
  logic [CsrDataWidth-1:0] sample_idx_q, sample_idx_d;
  logic                    cfg_load;
  logic                    run_active;
  logic                    fire;
  logic                    last_elem;
  logic                    last_sample;

  // The handshake is only open in RUN; this hides the counter's stale address
  // during LOAD and its wrapped address during PAUSE/DONE.
  assign run_active       = (state_q == RUN) && !stop_i;
  assign addr_if.addr_valid = run_active && cnt_addr_valid_i;
  assign cnt_addr_ready_o = run_active && addr_if.addr_ready;
  assign fire             = addr_if.addr_valid && addr_if.addr_ready;

  assign last_elem   = (elem_idx_q == num_elem_q - One);
  assign last_sample = (sample_idx_q == num_samples_q - One);

  assign addr_if.addr        = cnt_addr_i;
  assign addr_if.sample_last = (state_q == RUN) && last_elem;
  assign addr_if.elem_idx    = elem_idx_q;
  assign addr_if.sample_idx  = sample_idx_q;

  assign cnt_max_count_o   = num_elem_q;
  assign cnt_start_count_o = start_count_q;
  assign busy_o            = (state_q != IDLE);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    elem_idx_d   = elem_idx_q;
    sample_idx_d = sample_idx_q;
    cfg_load     = 1'b0;
    cnt_en_o     = 1'b0;
    cnt_start_o  = 1'b0;
    cnt_clr_o    = 1'b0;
    done_o       = 1'b0;

    if (stop_i && (state_q != IDLE)) begin
      // Abort wins over everything, including the done pulse.
      cnt_clr_o    = 1'b1;
      state_d      = IDLE;
      elem_idx_d   = '0;
      sample_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            cfg_load = 1'b1;
            state_d  = ((num_elem_i != '0) && (num_samples_i != '0)) ? LOAD : DONE;
          end
        end
        LOAD: begin
          cnt_en_o    = 1'b1;
          cnt_start_o = 1'b1;
          state_d     = RUN;
        end
        RUN: begin
          cnt_en_o = 1'b1;
          if (fire) begin
            if (last_elem) begin
              elem_idx_d = '0;
              if (last_sample) begin
                sample_idx_d = '0;
                state_d      = DONE;
              end else begin
                sample_idx_d = sample_idx_q + One;
                if (wait_ack_i) state_d = PAUSE;
              end
            end else begin
              elem_idx_d = elem_idx_q + One;
            end
          end
        end
        PAUSE: begin
          cnt_en_o = 1'b1;
          if (sample_ack_i) state_d = RUN;
        end
        DONE: begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      num_elem_q    <= '0;
      num_samples_q <= '0;
      start_count_q <= '0;
      elem_idx_q    <= '0;
      sample_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      elem_idx_q   <= elem_idx_d;
      sample_idx_q <= sample_idx_d;
      if (cfg_load) begin
        num_elem_q    <= num_elem_i;
        num_samples_q <= num_samples_i;
        start_count_q <= start_count_i;
      end
    end
  end

endmodule

// File: tb/tb_update_counter_ctrl.sv
// Self-checking bench for update_counter_ctrl: a behavioural address counter,
// an expected-beat queue built from the job config, and directed + random jobs.
module tb_update_counter_ctrl;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] elem;
    logic [W-1:0] sample;
    logic         last;
  } beat_t;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic         stop_i = 1'b0;
  logic         wait_ack_i = 1'b0;
  logic         sample_ack_i = 1'b0;
  logic [W-1:0] num_elem_i = '0;
  logic [W-1:0] num_samples_i = '0;
  logic [W-1:0] start_count_i = '0;
  logic         cnt_en_o, cnt_start_o, cnt_clr_o, cnt_addr_ready_o;
  logic         busy_o, done_o;
  logic [W-1:0] cnt_max_count_o, cnt_start_count_o;
  logic [W-1:0] cnt_addr_i;
  logic         cnt_addr_valid_i;
  logic         valid_gate = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  update_counter_ctrl_if #(.CsrDataWidth(W)) addr_if ();

  update_counter_ctrl #(.CsrDataWidth(W)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .stop_i           (stop_i),
    .wait_ack_i       (wait_ack_i),
    .num_elem_i       (num_elem_i),
    .num_samples_i    (num_samples_i),
    .start_count_i    (start_count_i),
    .sample_ack_i     (sample_ack_i),
    .cnt_en_o         (cnt_en_o),
    .cnt_start_o      (cnt_start_o),
    .cnt_clr_o        (cnt_clr_o),
    .cnt_max_count_o  (cnt_max_count_o),
    .cnt_start_count_o(cnt_start_count_o),
    .cnt_addr_i       (cnt_addr_i),
    .cnt_addr_valid_i (cnt_addr_valid_i),
    .cnt_addr_ready_o (cnt_addr_ready_o),
    .addr_if          (addr_if),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  // Behavioural item-memory address counter driven by the DUT's controls.
  logic [W-1:0] c_addr, c_cnt;
  logic         c_valid;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_addr <= '0; c_cnt <= '0; c_valid <= 1'b0;
    end else if (cnt_clr_o || !cnt_en_o) begin
      c_addr <= '0; c_cnt <= '0; c_valid <= 1'b0;
    end else if (cnt_start_o) begin
      c_addr <= cnt_start_count_o; c_cnt <= '0; c_valid <= 1'b1;
    end else if (cnt_addr_valid_i && cnt_addr_ready_o) begin
      if (c_cnt == cnt_max_count_o - 1) begin
        c_addr <= cnt_start_count_o; c_cnt <= '0;
      end else begin
        c_addr <= c_addr + 1; c_cnt <= c_cnt + 1;
      end
    end
  end
  assign cnt_addr_i       = c_addr;
  assign cnt_addr_valid_i = c_valid && valid_gate;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic to_next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_en"}, cnt_en_o, 0);
    check({tag, "_start"}, cnt_start_o, 0);
    check({tag, "_clr"}, cnt_clr_o, 0);
    check({tag, "_valid"}, addr_if.addr_valid, 0);
    check({tag, "_cready"}, cnt_addr_ready_o, 0);
    check({tag, "_last"}, addr_if.sample_last, 0);
    check({tag, "_elem"}, addr_if.elem_idx, 0);
    check({tag, "_sample"}, addr_if.sample_idx, 0);
    check({tag, "_maxcnt"}, cnt_max_count_o, 0);
    check({tag, "_startcnt"}, cnt_start_count_o, 0);
    check({tag, "_addr"}, addr_if.addr, 0);
  endtask

  // Exact-cycle check of the reference job: start_count=10, 3 x 2, ready=1.
  task automatic basic_job();
    int k;
    num_elem_i = 3; num_samples_i = 2; start_count_i = 10;
    wait_ack_i = 0; addr_if.addr_ready = 1; valid_gate = 1;
    start_i = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      k = c - 2;
      check("basic_valid", addr_if.addr_valid, (c >= 2 && c <= 7));
      if (c >= 2 && c <= 7) begin
        check("basic_addr", addr_if.addr, 10 + (k % 3));
        check("basic_last", addr_if.sample_last, (k % 3) == 2);
        check("basic_elem", addr_if.elem_idx, k % 3);
        check("basic_sample", addr_if.sample_idx, k / 3);
      end
      check("basic_busy", busy_o, (c >= 1 && c <= 8));
      check("basic_done", done_o, c == 8);
      check("basic_cnt_start", cnt_start_o, c == 1);
      check("basic_cnt_en", cnt_en_o, (c >= 1 && c <= 7));
      to_next();
      start_i = 0;
    end
  endtask

  // rmode: 0 ready always high, 1 ready toggling 1,0, 2 random ready/valid.
  // stop_cyc: RUN-phase cycle that gets stop_i (-1 none); ack_dly -1 = random.
  task automatic run_job(input int ne, input int ns, input int sc, input bit wa,
                         input int rmode, input int stop_cyc, input int ack_dly,
                         input bit noise);
    beat_t q[$];
    beat_t e;
    int    delay;
    bit    pausing;
    bit    finished;
    bit    fire;

    num_elem_i = ne; num_samples_i = ns; start_count_i = sc;
    wait_ack_i = wa; stop_i = 0; sample_ack_i = 0; valid_gate = 1;
    addr_if.addr_ready = 1;
    start_i = 1;
    @(negedge clk_i);
    check("start_idle_busy", busy_o, 0);
    to_next();
    start_i = 0;
    // A running job must ignore any later CSR change.
    num_elem_i = $urandom; num_samples_i = $urandom; start_count_i = $urandom;

    if (ne == 0 || ns == 0) begin
      @(negedge clk_i);
      check("empty_done", done_o, 1);
      check("empty_en", cnt_en_o, 0);
      check("empty_valid", addr_if.addr_valid, 0);
      to_next();
      @(negedge clk_i);
      check("empty_busy", busy_o, 0);
      check("empty_done_once", done_o, 0);
      check("empty_en_idle", cnt_en_o, 0);
      to_next();
      return;
    end

    for (int s = 0; s < ns; s++)
      for (int i = 0; i < ne; i++)
        q.push_back('{addr: W'(sc + i), elem: W'(i), sample: W'(s), last: (i == ne - 1)});

    @(negedge clk_i);
    check("load_start", cnt_start_o, 1);
    check("load_en", cnt_en_o, 1);
    check("load_valid", addr_if.addr_valid, 0);
    to_next();

    pausing = 0; finished = 0; delay = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      case (rmode)
        0:       addr_if.addr_ready = 1;
        1:       addr_if.addr_ready = (cyc % 2 == 0);
        default: addr_if.addr_ready = 1'($urandom_range(0, 1));
      endcase
      valid_gate   = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      stop_i       = (cyc == stop_cyc);
      sample_ack_i = 0;
      start_i      = noise && ($urandom_range(0, 7) == 0);
      if (pausing) sample_ack_i = (delay == 0);
      else if (noise) sample_ack_i = ($urandom_range(0, 5) == 0);

      @(negedge clk_i);
      check("latched_max", cnt_max_count_o, ne);
      check("latched_start", cnt_start_count_o, sc);
      if (stop_i) begin
        check("stop_clr", cnt_clr_o, 1);
        to_next();
        stop_i = 0; sample_ack_i = 0; start_i = 0;
        @(negedge clk_i);
        check("stop_busy", busy_o, 0);
        check("stop_done", done_o, 0);
        check("stop_elem", addr_if.elem_idx, 0);
        check("stop_sample", addr_if.sample_idx, 0);
        to_next();
        return;
      end
      check("run_clr", cnt_clr_o, 0);
      check("run_en", cnt_en_o, 1);
      if (pausing) begin
        check("pause_valid", addr_if.addr_valid, 0);
        check("pause_cready", cnt_addr_ready_o, 0);
        check("pause_last", addr_if.sample_last, 0);
        if (delay == 0) pausing = 0;
        else delay--;
      end else begin
        check("run_valid", addr_if.addr_valid, cnt_addr_valid_i);
        check("run_cready", cnt_addr_ready_o, addr_if.addr_ready);
        fire = addr_if.addr_valid && addr_if.addr_ready;
        if (fire) begin
          check("beats_left", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("beat_addr", addr_if.addr, e.addr);
            check("beat_elem", addr_if.elem_idx, e.elem);
            check("beat_sample", addr_if.sample_idx, e.sample);
            check("beat_last", addr_if.sample_last, e.last);
            if (e.last) begin
              if (q.size() == 0) finished = 1;
              else if (wa) begin
                pausing = 1;
                delay   = (ack_dly < 0) ? $urandom_range(0, 5) : ack_dly;
              end
            end
          end
        end
      end
      to_next();
    end

    start_i = 0; sample_ack_i = 0; stop_i = 0;
    check("job_in_budget", finished, 1);
    if (!finished) return;
    @(negedge clk_i);
    check("done_pulse", done_o, 1);
    check("done_busy", busy_o, 1);
    check("done_en", cnt_en_o, 0);
    check("done_valid", addr_if.addr_valid, 0);
    to_next();
    @(negedge clk_i);
    check("idle_busy", busy_o, 0);
    check("idle_done", done_o, 0);
    to_next();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ne, ns, stop_cyc;
    addr_if.addr_ready = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    #1 rst_ni = 1;
    to_next();

    basic_job();
    run_job(3, 2, 10, 0, 1, -1, 0, 0);      // backpressure
    run_job(2, 3, 40, 1, 0, -1, 5, 0);      // ack pause, 5 cycles
    run_job(0, 3, 7, 0, 0, -1, 0, 0);       // empty: no elements
    run_job(3, 0, 7, 0, 0, -1, 0, 0);       // empty: no samples
    run_job(3, 2, 10, 0, 0, 1, 0, 0);       // abort on 2nd beat of sample 1
    run_job(3, 2, 10, 0, 0, -1, 0, 0);      // clean restart after abort

    // start and stop together in IDLE: start is dropped
    num_elem_i = 2; num_samples_i = 2; start_i = 1; stop_i = 1;
    @(negedge clk_i);
    check("idle_stop_clr", cnt_clr_o, 0);
    to_next();
    start_i = 0; stop_i = 0;
    @(negedge clk_i);
    check("idle_stop_busy", busy_o, 0);
    check("idle_stop_en", cnt_en_o, 0);
    to_next();

    for (int j = 0; j < 40; j++) begin
      ne = $urandom_range(0, 5);
      ns = $urandom_range(0, 4);
      stop_cyc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, ne * ns * 2 + 1) : -1;
      run_job(ne, ns, $urandom_range(0, 1000), 1'($urandom_range(0, 1)), 2,
              stop_cyc, -1, 1);
    end

    // Mid-job reset
    num_elem_i = 4; num_samples_i = 3; start_count_i = 55; wait_ack_i = 0;
    addr_if.addr_ready = 1; valid_gate = 1; start_i = 1;
    to_next();
    start_i = 0;
    repeat (4) to_next();
    rst_ni = 0;
    #1;
    addr_if.addr_ready = 0;
    #1;
    check_all_zero("midreset");
    @(negedge clk_i);
    rst_ni = 1;
    to_next();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
